pc_unit: RTL and testbench

- Parametrised next-generation program counter for the MIPS pipeline.
- Holds the fetch address and selects the next PC from these sources:
  - exception vector
  - EX-stage branch redirect
  - return-address-stack (RAS) prediction
  - jump target
  - sequential increment
- Supports pipeline stalls and a small RAS for call/return.
- Sits at the head of the IF stage and feeds instruction memory and the IF/ID register.

---
 rtl/pc_unit.sv | 94 +++++++++
 tb/tb_pc_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - next-PC selection with stall, exception, branch, jump and return-address stack
module pc_unit #(
  parameter int                 WIDTH      = 32,
  parameter logic [WIDTH-1:0]   RESET_ADDR = 32'h00000000,
  parameter logic [WIDTH-1:0]   EXC_VECTOR = 32'h80000180,
  parameter int                 INC        = 4,
  parameter int                 RAS_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           exc_req,
  input  logic                           branch_taken,
  input  logic [WIDTH-1:0]               branch_target,
  input  logic                           jump,
  input  logic                           call,
  input  logic [WIDTH-1:0]               jump_target,
  input  logic                           ret,
  output logic [WIDTH-1:0]               pc_out,
  output logic [WIDTH-1:0]               pc_plus,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);

  // Stack storage; wr_ptr is the slot the next push writes, the entry below it is top-of-stack.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt, ptr_inc, ptr_dec;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             push;

  assign pc_plus   = pc_out + WIDTH'(INC);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CNT_MAX);
  assign ptr_inc   = (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
  assign ptr_dec   = (wr_ptr == '0) ? PTR_MAX : wr_ptr - 1'b1;

  // Prioritised next-PC and stack-pointer selection.
  always_comb begin
    pc_nxt     = pc_out;
    cnt_nxt    = ras_count;
    wr_ptr_nxt = wr_ptr;
    push       = 1'b0;
    if (exc_req) begin
      pc_nxt  = EXC_VECTOR;
      cnt_nxt = '0;
    end else if (!enable) begin
      pc_nxt = pc_out;
    end else if (branch_taken) begin
      pc_nxt = {branch_target[WIDTH-1:2], 2'b00};
    end else if (ret && !ras_empty) begin
      pc_nxt     = ras_mem[ptr_dec];
      wr_ptr_nxt = ptr_dec;
      cnt_nxt    = ras_count - 1'b1;
    end else if (jump && !ret) begin
      pc_nxt = {jump_target[WIDTH-1:2], 2'b00};
      if (call) begin
        push       = 1'b1;
        wr_ptr_nxt = ptr_inc;
        // A push into a full stack overwrites the oldest slot, so the count saturates.
        cnt_nxt    = ras_full ? ras_count : ras_count + 1'b1;
      end
    end else begin
      pc_nxt = pc_plus;
    end
  end

  // PC, stack pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_out    <= RESET_ADDR;
      ras_count <= '0;
      wr_ptr    <= '0;
    end else begin
      pc_out    <= pc_nxt;
      ras_count <= cnt_nxt;
      wr_ptr    <= wr_ptr_nxt;
    end
  end

  // Stack contents are not reset; only the count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      ras_mem[wr_ptr] <= pc_plus;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        exc_req;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        call;
  logic [31:0] jump_target;
  logic        ret;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;

  int tests_run = 0;
  int tests_failed = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .enable(enable), .exc_req(exc_req),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .call(call), .jump_target(jump_target), .ret(ret),
    .pc_out(pc_out), .pc_plus(pc_plus), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation and tally the result.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    exc_req = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
  endtask

  task automatic do_call(input logic [31:0] tgt);
    clear_ctl(); jump = 1; call = 1; jump_target = tgt;
    step();
  endtask

  task automatic do_branch(input logic [31:0] tgt);
    clear_ctl(); branch_taken = 1; branch_target = tgt;
    step();
  endtask

  logic [31:0] ret_pc  [5] = '{32'h44, 32'h34, 32'h24, 32'h14, 32'h18};
  logic [2:0]  ret_cnt [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

  initial begin
    reset = 0; enable = 0; branch_target = 0; jump_target = 0;
    clear_ctl();
    step();
    check("reset_pc", pc_out, 32'h0);
    check("reset_cnt", {29'b0, ras_count}, 32'd0);
    check("reset_empty", {31'b0, ras_empty}, 32'd1);
    check("reset_full", {31'b0, ras_full}, 32'd0);

    // Sequential fetch then stall.
    reset = 1; enable = 1;
    step(); check("seq_1", pc_out, 32'h4);
    step(); check("seq_2", pc_out, 32'h8);
    step(); check("seq_3", pc_out, 32'hC);
    check("pc_plus", pc_plus, 32'h10);
    enable = 0;
    step(); check("stall_1", pc_out, 32'hC);
    step(); check("stall_2", pc_out, 32'hC);
    enable = 1;
    step(); check("resume", pc_out, 32'h10);

    // Branch outranks ret and call at the same time.
    clear_ctl();
    branch_taken = 1; branch_target = 32'h100;
    jump = 1; call = 1; jump_target = 32'h200; ret = 1;
    step();
    check("prio_pc", pc_out, 32'h100);
    check("prio_cnt", {29'b0, ras_count}, 32'd0);

    // Call then return.
    do_branch(32'h20);
    check("at_20", pc_out, 32'h20);
    do_call(32'h400);
    check("call_pc", pc_out, 32'h400);
    check("call_cnt", {29'b0, ras_count}, 32'd1);
    clear_ctl(); ret = 1;
    step();
    check("ret_pc", pc_out, 32'h24);
    check("ret_cnt", {29'b0, ras_count}, 32'd0);

    // Overflow: five calls into a four-entry stack.
    do_branch(32'h0);
    do_call(32'h10);
    do_call(32'h20);
    do_call(32'h30);
    do_call(32'h40);
    check("full_at_4", {31'b0, ras_full}, 32'd1);
    do_call(32'h50);
    check("ovf_pc", pc_out, 32'h50);
    check("ovf_cnt", {29'b0, ras_count}, 32'd4);
    check("ovf_full", {31'b0, ras_full}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      clear_ctl(); ret = 1;
      step();
      check($sformatf("ovf_ret_pc_%0d", i), pc_out, ret_pc[i]);
      check($sformatf("ovf_ret_cnt_%0d", i), {29'b0, ras_count}, {29'b0, ret_cnt[i]});
    end
    check("underflow_empty", {31'b0, ras_empty}, 32'd1);

    // Exception while stalled flushes the stack.
    do_call(32'h100);
    do_call(32'h200);
    check("pre_exc_cnt", {29'b0, ras_count}, 32'd2);
    clear_ctl(); enable = 0; exc_req = 1;
    step();
    check("exc_pc", pc_out, 32'h80000180);
    check("exc_cnt", {29'b0, ras_count}, 32'd0);
    clear_ctl(); enable = 1;

    // Reset beats a pending jump.
    jump = 1; jump_target = 32'h300; reset = 0;
    step();
    check("rst_jump_pc", pc_out, 32'h0);
    check("rst_jump_cnt", {29'b0, ras_count}, 32'd0);
    reset = 1;

    // Target alignment.
    clear_ctl(); jump = 1; jump_target = 32'h403;
    step();
    check("align_pc", pc_out, 32'h400);

    // Wrap-around of the sequential increment.
    jump_target = 32'hFFFFFFFC;
    step();
    check("wrap_pre", pc_out, 32'hFFFFFFFC);
    check("wrap_plus", pc_plus, 32'h0);
    clear_ctl();
    step();
    check("wrap_pc", pc_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
